// File: rtl/mcc_nibble_subtractor_pkg.sv
// Shared widths and FSM encoding for the nibble-serial subtractor.
// The top takes its parameter defaults from here.
package mcc_nibble_subtractor_pkg;

    localparam int DATA_W  = 16;
    localparam int NIB_W   = 4;
    localparam int NUM_NIB = DATA_W / NIB_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/mcc_nib_chain.sv
// One nibble of a Manchester carry chain: propagate/generate/kill per bit,
// producing the nibble sum and its carry-out.
module mcc_nib_chain #(
    parameter int NIB_W = 4
) (
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] kill;
    logic [NIB_W:0]   c;

    assign p    = a ^ b;
    assign g    = a & b;
    assign kill = ~p & ~g;

    // Each stage generates, kills, or passes the incoming carry unchanged.
    // NOTE: c gets a full default before the loop so no bit can hold a previous value (no latch).
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < NIB_W; i++) begin
            c[i+1] = g[i] | (c[i] & ~kill[i]);
        end
    end

    assign sum  = p ^ c[NIB_W-1:0];
    assign cout = c[NIB_W];

endmodule

// File: rtl/mcc_nibble_subtractor.sv
// Nibble-serial subtractor: a - b computed as a + ~b + 1, one nibble per cycle
// through a single shared carry-chain instance, with valid/ready handshakes.
module mcc_nibble_subtractor #(
    parameter int DATA_W = mcc_nibble_subtractor_pkg::DATA_W,
    parameter int NIB_W  = mcc_nibble_subtractor_pkg::NIB_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] diff,
    output logic              borrow,
    output logic              ovf
);

    import mcc_nibble_subtractor_pkg::*;

    localparam int NUM_NIB = DATA_W / NIB_W;
    localparam int CNT_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam int MSB     = DATA_W - 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NUM_NIB - 1);

    state_t            state;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] nb_q;
    logic [CNT_W-1:0]  cnt;
    logic              carry;

    logic [NIB_W-1:0]  nib_a;
    logic [NIB_W-1:0]  nib_nb;
    logic [NIB_W-1:0]  nib_sum;
    logic              nib_cout;

    assign nib_a  = a_q[cnt*NIB_W +: NIB_W];
    assign nib_nb = nb_q[cnt*NIB_W +: NIB_W];

    mcc_nib_chain #(
        .NIB_W (NIB_W)
    ) u_chain (
        .a    (nib_a),
        .b    (nib_nb),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    assign in_ready  = (state == IDLE);
    assign res_valid = (state == DONE);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            nb_q   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        nb_q  <= ~b;
                        cnt   <= '0;
                        carry <= 1'b1;
                        diff  <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    diff[cnt*NIB_W +: NIB_W] <= nib_sum;
                    carry <= nib_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_NIB) begin
                        // nb_q holds ~b, so equal MSBs here mean a and b differ in sign.
                        borrow <= ~nib_cout;
                        ovf    <= (a_q[MSB] == nb_q[MSB]) && (nib_sum[NIB_W-1] != a_q[MSB]);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcc_nibble_subtractor.sv
// Self-checking bench for mcc_nibble_subtractor: directed corner cases, hold,
// mid-run reset and randomized operands against an arithmetic reference model.
module tb_mcc_nibble_subtractor;

    localparam int DATA_W  = 16;
    localparam int NIB_W   = 4;
    localparam int LATENCY = DATA_W / NIB_W;
    localparam int TIMEOUT = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] diff;
    logic              borrow;
    logic              ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mcc_nibble_subtractor #(
        .DATA_W (DATA_W),
        .NIB_W  (NIB_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf)
    );

    // Reference: plain integer arithmetic, unsigned for borrow, signed for overflow.
    function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] d, output logic br, output logic ov);
        int ud;
        int sd;
        ud = int'(x) - int'(y);
        d  = ud[15:0];
        br = (x < y);
        sd = int'($signed(x)) - int'($signed(y));
        ov = (sd > 32767) || (sd < -32768);
    endfunction

    // Runs one operation from IDLE, scrambling inputs while it is in flight.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] d, output logic br, output logic ov,
                         output int lat);
        a = x;
        b = y;
        in_valid  = 1'b1;
        res_ready = 1'b0;
        @(posedge clk); #1;
        lat = 0;
        while (!res_valid && lat < TIMEOUT) begin
            a        = 16'($urandom);
            b        = 16'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        d  = diff;
        br = borrow;
        ov = ovf;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_res_valid: got %b expected 0", res_valid);
        end
        checks++;
        if ({diff, borrow, ovf} !== 18'h0) begin
            failures++;
            $display("FAIL reset_outputs: got diff=%h borrow=%b ovf=%b expected all 0", diff, borrow, ovf);
        end
    endtask

    task automatic test_directed();
        logic [15:0] av [6];
        logic [15:0] bv [6];
        logic [15:0] ed [6];
        logic        eb [6];
        logic        eo [6];
        logic [15:0] d;
        logic        br;
        logic        ov;
        int          lat;
        av = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF, 16'hA5A5, 16'hFFFF};
        bv = '{16'h0234, 16'h0001, 16'h0001, 16'hFFFF, 16'hA5A5, 16'h0000};
        ed = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
        eb = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b0};
        eo = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b0};
        for (int i = 0; i < 6; i++) begin
            do_op(av[i], bv[i], d, br, ov, lat);
            checks++;
            if (lat !== LATENCY) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LATENCY);
            end
            checks++;
            if ({d, br, ov} !== {ed[i], eb[i], eo[i]}) begin
                failures++;
                $display("FAIL directed[%0d] %h-%h: got diff=%h borrow=%b ovf=%b expected diff=%h borrow=%b ovf=%b",
                         i, av[i], bv[i], d, br, ov, ed[i], eb[i], eo[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [15:0] ed;
        logic        eb;
        logic        eo;
        int          lat;
        model(16'hC3A1, 16'h5B72, ed, eb, eo);
        a = 16'hC3A1;
        b = 16'h5B72;
        in_valid  = 1'b1;
        res_ready = 1'b0;
        @(posedge clk); #1;
        lat = 0;
        while (!res_valid && lat < TIMEOUT) begin
            a        = 16'($urandom);
            b        = 16'($urandom);
            in_valid = 1'b0;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_run_in_ready: got %b expected 0", in_ready);
            end
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            a        = 16'($urandom);
            b        = 16'($urandom);
            in_valid = 1'b1;
            checks++;
            if ({res_valid, in_ready, diff, borrow, ovf} !== {1'b1, 1'b0, ed, eb, eo}) begin
                failures++;
                $display("FAIL hold[%0d]: got valid=%b ready=%b diff=%h borrow=%b ovf=%b expected valid=1 ready=0 diff=%h borrow=%b ovf=%b",
                         i, res_valid, in_ready, diff, borrow, ovf, ed, eb, eo);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if ({in_ready, res_valid} !== 2'b10) begin
            failures++;
            $display("FAIL hold_release: got ready=%b valid=%b expected ready=1 valid=0", in_ready, res_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] d;
        logic        br;
        logic        ov;
        int          lat;
        int          seen;
        a = 16'h4321;
        b = 16'h1111;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({in_ready, res_valid, diff, borrow, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset: got ready=%b valid=%b diff=%h borrow=%b ovf=%b expected ready=1 valid=0 diff=0000 borrow=0 ovf=0",
                     in_ready, res_valid, diff, borrow, ovf);
        end
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL mid_reset_no_result: got %0d valid cycles expected 0", seen);
        end
        do_op(16'h00F0, 16'h000F, d, br, ov, lat);
        checks++;
        if ({d, br, ov, lat} !== {16'h00E1, 1'b0, 1'b0, LATENCY}) begin
            failures++;
            $display("FAIL after_reset_op: got diff=%h borrow=%b ovf=%b lat=%0d expected diff=00e1 borrow=0 ovf=0 lat=%0d",
                     d, br, ov, lat, LATENCY);
        end
    endtask

    task automatic test_random(input int n);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] d;
        logic [15:0] ed;
        logic        br;
        logic        ov;
        logic        eb;
        logic        eo;
        int          lat;
        for (int i = 0; i < n; i++) begin
            x = 16'($urandom);
            case ($urandom_range(0, 7))
                0: y = x;
                1: y = {~x[15], 15'($urandom)};
                default: y = 16'($urandom);
            endcase
            model(x, y, ed, eb, eo);
            do_op(x, y, d, br, ov, lat);
            checks++;
            if ({br, d} !== {eb, ed} || lat !== LATENCY) begin
                failures++;
                $display("FAIL random[%0d] %h-%h: got borrow=%b diff=%h lat=%0d expected borrow=%b diff=%h lat=%0d",
                         i, x, y, br, d, lat, eb, ed, LATENCY);
            end
            checks++;
            if (ov !== eo) begin
                failures++;
                $display("FAIL random_ovf[%0d] %h-%h: got %b expected %b", i, x, y, ov, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid_run();
        test_random(3000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
